// File: rtl/svga_vram_arbiter_pkg.sv
// Shared types for the SVGA VRAM arbiter: owner tags for in-flight accesses
// and the starvation counter width.
package svga_vram_arbiter_pkg;

    localparam int STARVE_CNT_W = 8;

    // Who owns the access currently travelling through the VRAM read stage
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_VID    = 2'd1,
        OWN_CPU_RD = 2'd2,
        OWN_CPU_WR = 2'd3
    } owner_t;

endpackage

// File: rtl/svga_vram_arbiter_if.sv
// Bus bundle around the VRAM arbiter: video fetch port, CPU port and the
// single-port VRAM macro port. The slave side is the arbiter itself.
interface svga_vram_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 32
);
    localparam int STRB_W = DATA_W / 8;

    // video scanout fetch
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_gnt;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;

    // CPU bus
    logic              cpu_valid;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic [STRB_W-1:0] cpu_wstrb;
    logic              cpu_ready;
    logic [DATA_W-1:0] cpu_rdata;

    // VRAM macro
    logic              mem_en;
    logic [STRB_W-1:0] mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  vid_req, vid_addr,
        output vid_gnt, vid_rvalid, vid_rdata,
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        output cpu_ready, cpu_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output vid_req, vid_addr,
        input  vid_gnt, vid_rvalid, vid_rdata,
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
        input  cpu_ready, cpu_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/svga_vram_arbiter.sv
// Single-port VRAM arbiter between scanout video fetch (fixed priority) and
// the CPU bus. A saturating starvation counter forces one CPU slot after
// STARVE_LIMIT consecutive denied cycles. One access is issued per cycle; an
// owner tag follows each access so read data strobes reach only its owner.
module svga_vram_arbiter
    import svga_vram_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 8
) (
    input logic               clk,
    input logic               reset,
    svga_vram_arbiter_if.slave bus
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [STARVE_CNT_W-1:0] LIMIT   = STARVE_CNT_W'(STARVE_LIMIT);
    localparam logic [STARVE_CNT_W-1:0] CNT_MAX = '1;

    logic                    cpu_busy;
    logic [STARVE_CNT_W-1:0] starve_cnt;
    owner_t                  owner_q;
    logic                    starved;
    logic                    cpu_win;
    logic                    vid_win;

    // Slot decision from the current inputs; nothing is granted while in reset
    assign starved = (starve_cnt >= LIMIT);
    assign cpu_win = !reset && bus.cpu_valid && !cpu_busy && (!bus.vid_req || starved);
    assign vid_win = !reset && bus.vid_req && !cpu_win;

    assign bus.vid_gnt = vid_win;

    // Read data fans out to both requesters; only the strobes are owner-qualified
    assign bus.vid_rdata = bus.mem_rdata;
    assign bus.cpu_rdata = bus.mem_rdata;

    // Issue stage: register the winner's access onto the VRAM port with its owner tag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= '0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            owner_q       <= OWN_NONE;
        end else if (cpu_win) begin
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= bus.cpu_we ? bus.cpu_wstrb : {STRB_W{1'b0}};
            bus.mem_addr  <= bus.cpu_addr;
            bus.mem_wdata <= bus.cpu_wdata;
            owner_q       <= bus.cpu_we ? OWN_CPU_WR : OWN_CPU_RD;
        end else if (vid_win) begin
            bus.mem_en    <= 1'b1;
            bus.mem_we    <= '0;
            bus.mem_addr  <= bus.vid_addr;
            owner_q       <= OWN_VID;
        end else begin
            bus.mem_en    <= 1'b0;
            bus.mem_we    <= '0;
            owner_q       <= OWN_NONE;
        end
    end

    // Return stage: the tag of last cycle's access turns into the owner's strobe,
    // lining up with mem_rdata one cycle after mem_en
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.vid_rvalid <= 1'b0;
            bus.cpu_ready  <= 1'b0;
        end else begin
            bus.vid_rvalid <= (owner_q == OWN_VID);
            bus.cpu_ready  <= (owner_q == OWN_CPU_RD) || (owner_q == OWN_CPU_WR);
        end
    end

    // One outstanding CPU access: busy from grant until the ready pulse has been seen,
    // so a request still held during its ready cycle is not issued twice
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_busy <= 1'b0;
        end else if (cpu_win) begin
            cpu_busy <= 1'b1;
        end else if (bus.cpu_ready) begin
            cpu_busy <= 1'b0;
        end
    end

    // Starvation counter: counts denied cycles of a pending, non-busy CPU request,
    // clears on CPU grant or idle CPU, freezes while busy, saturates at the top
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (cpu_win || !bus.cpu_valid) begin
            starve_cnt <= '0;
        end else if (!cpu_busy && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_svga_vram_arbiter.sv
// Directed bench for svga_vram_arbiter with a behavioural single-port VRAM.
module tb_svga_vram_arbiter;

    localparam int ADDR_W = 15;
    localparam int DATA_W = 32;
    localparam logic [31:0] PAT = 32'hA5A5A5A5;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    svga_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    svga_vram_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model: words never written read back as an address pattern,
    // except 0x100..0x1FF which start at zero
    logic [31:0] vram     [0:1023];
    logic        written  [0:1023];

    function automatic logic [31:0] init_word(input logic [ADDR_W-1:0] a);
        if (a >= 15'h100 && a < 15'h200) return 32'h0;
        return {17'h0, a} ^ PAT;
    endfunction

    function automatic logic [31:0] rd_word(input logic [ADDR_W-1:0] a);
        if (written[a[9:0]] === 1'b1) return vram[a[9:0]];
        return init_word(a);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // synchronous VRAM: read data appears the cycle after mem_en
    always @(posedge clk) begin
        if (bus.mem_en) begin
            bus.mem_rdata <= rd_word(bus.mem_addr);
            if (bus.mem_we != 4'b0000) begin
                vram[bus.mem_addr[9:0]]    <= merge(rd_word(bus.mem_addr), bus.mem_wdata, bus.mem_we);
                written[bus.mem_addr[9:0]] <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.cpu_valid = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        bus.cpu_wstrb = '0;
    endtask

    int vid_gnts;
    int vid_rets;
    int cpu_rets;

    initial begin
        checks = 0;
        errors = 0;
        vid_gnts = 0;
        vid_rets = 0;
        cpu_rets = 0;
        bus.mem_rdata = '0;
        idle_inputs();

        // ---------------- reset state, video request held during reset
        reset = 1'b1;
        bus.vid_req = 1'b1;
        tick();
        tick();
        chk("rst_mem_en",    bus.mem_en, 0);
        chk("rst_mem_we",    bus.mem_we, 0);
        chk("rst_mem_addr",  bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_vid_rvalid", bus.vid_rvalid, 0);
        chk("rst_cpu_ready", bus.cpu_ready, 0);
        chk("rst_vid_gnt",   bus.vid_gnt, 0);
        chk("rst_starve",    dut.starve_cnt, 0);
        idle_inputs();
        reset = 1'b0;
        tick();

        // ---------------- video-only stream 0x10..0x13
        for (int c = 0; c < 6; c++) begin
            bus.vid_req  = (c < 4);
            bus.vid_addr = 15'(16'h10 + c);
            #1;
            chk("vs_gnt", bus.vid_gnt, (c < 4));
            chk("vs_mem_en", bus.mem_en, (c >= 1 && c <= 4));
            if (c >= 1 && c <= 4) chk("vs_mem_addr", bus.mem_addr, 16'h10 + c - 1);
            chk("vs_rvalid", bus.vid_rvalid, (c >= 2));
            if (c >= 2) chk("vs_rdata", bus.vid_rdata, (32'h10 + c - 2) ^ PAT);
            chk("vs_cpu_ready", bus.cpu_ready, 0);
            tick();
        end
        idle_inputs();
        tick();

        // ---------------- CPU write 0x100, then read it back on an idle bus
        bus.cpu_valid = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_addr  = 15'h100;
        bus.cpu_wdata = 32'hDEADBEEF;
        bus.cpu_wstrb = 4'b0011;
        #1;
        chk("wr_vid_gnt", bus.vid_gnt, 0);
        tick();
        chk("wr_mem_en",    bus.mem_en, 1);
        chk("wr_mem_we",    bus.mem_we, 4'b0011);
        chk("wr_mem_addr",  bus.mem_addr, 15'h100);
        chk("wr_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
        chk("wr_ready_early", bus.cpu_ready, 0);
        tick();
        chk("wr_ready", bus.cpu_ready, 1);
        chk("wr_mem_en_off", bus.mem_en, 0);
        bus.cpu_valid = 1'b0;
        tick();
        chk("wr_ready_pulse", bus.cpu_ready, 0);
        bus.cpu_valid = 1'b1;
        bus.cpu_we    = 1'b0;
        tick();
        chk("rd_mem_en",   bus.mem_en, 1);
        chk("rd_mem_we",   bus.mem_we, 4'b0000);
        chk("rd_mem_addr", bus.mem_addr, 15'h100);
        tick();
        chk("rd_ready",  bus.cpu_ready, 1);
        chk("rd_rdata",  bus.cpu_rdata, 32'h0000BEEF);
        chk("rd_vid_rvalid", bus.vid_rvalid, 0);
        bus.cpu_valid = 1'b0;
        tick();
        chk("rd_ready_pulse", bus.cpu_ready, 0);
        idle_inputs();
        tick();

        // ---------------- starvation, busy freeze and routing isolation
        // CPU wins at cycles 8 and 19: 8 denials, grant, 2 busy cycles that must
        // not count, then 8 more denials.
        for (int c = 0; c < 22; c++) begin
            bus.vid_req   = 1'b1;
            bus.vid_addr  = 15'(16'h20 + c);
            bus.cpu_valid = 1'b1;
            bus.cpu_we    = 1'b0;
            bus.cpu_addr  = (c >= 10) ? 15'h201 : 15'h200;
            #1;
            chk("st_gnt", bus.vid_gnt, !(c == 8 || c == 19));
            if (c >= 1) begin
                chk("st_mem_en", bus.mem_en, 1);
                chk("st_mem_addr", bus.mem_addr,
                    (c == 9) ? 16'h200 : (c == 20) ? 16'h201 : 16'h20 + c - 1);
            end
            chk("st_cpu_ready", bus.cpu_ready, (c == 10 || c == 21));
            if (c == 10 || c == 21)
                chk("st_cpu_rdata", bus.cpu_rdata, ((c == 10) ? 32'h200 : 32'h201) ^ PAT);
            chk("st_vid_rvalid", bus.vid_rvalid, (c >= 2 && c != 10 && c != 21));
            if (c >= 2 && c != 10 && c != 21)
                chk("st_vid_rdata", bus.vid_rdata, (32'h20 + c - 2) ^ PAT);
            chk("iso_overlap", bus.cpu_ready & bus.vid_rvalid, 0);
            vid_gnts += int'(bus.vid_gnt);
            vid_rets += int'(bus.vid_rvalid);
            cpu_rets += int'(bus.cpu_ready);
            tick();
        end
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            #1;
            vid_rets += int'(bus.vid_rvalid);
            cpu_rets += int'(bus.cpu_ready);
            tick();
        end
        chk("iso_vid_returns", vid_rets, vid_gnts);
        chk("iso_vid_grants", vid_gnts, 20);
        chk("iso_cpu_returns", cpu_rets, 2);

        // ---------------- counter clears when cpu_valid drops
        for (int c = 0; c < 15; c++) begin
            bus.vid_req   = 1'b1;
            bus.vid_addr  = 15'h40;
            bus.cpu_valid = (c != 5);
            bus.cpu_addr  = 15'h204;
            #1;
            if (c == 5) chk("cc_cnt_before_drop", dut.starve_cnt, 5);
            if (c == 6) chk("cc_cnt_after_drop", dut.starve_cnt, 0);
            chk("cc_gnt", bus.vid_gnt, (c != 14));
            tick();
        end
        idle_inputs();
        tick();
        chk("cc_ready", bus.cpu_ready, 1);
        chk("cc_rdata", bus.cpu_rdata, 32'h204 ^ PAT);
        tick();
        tick();

        // ---------------- async reset in the cycle after a CPU read grant
        bus.cpu_valid = 1'b1;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = 15'h300;
        tick();
        chk("ar_mem_en", bus.mem_en, 1);
        chk("ar_mem_addr", bus.mem_addr, 15'h300);
        reset = 1'b1;
        bus.vid_req = 1'b1;
        #1;
        chk("ar_mem_en_rst", bus.mem_en, 0);
        chk("ar_ready_rst", bus.cpu_ready, 0);
        chk("ar_rvalid_rst", bus.vid_rvalid, 0);
        chk("ar_gnt_rst", bus.vid_gnt, 0);
        idle_inputs();
        tick();
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("ar_no_ready", bus.cpu_ready, 0);
            chk("ar_no_rvalid", bus.vid_rvalid, 0);
            chk("ar_no_mem_en", bus.mem_en, 0);
            tick();
        end
        bus.cpu_valid = 1'b1;
        bus.cpu_addr  = 15'h300;
        tick();
        chk("ar_post_mem_en", bus.mem_en, 1);
        chk("ar_post_mem_we", bus.mem_we, 0);
        tick();
        chk("ar_post_ready", bus.cpu_ready, 1);
        chk("ar_post_rdata", bus.cpu_rdata, 32'h300 ^ PAT);
        idle_inputs();
        tick();
        chk("ar_post_pulse", bus.cpu_ready, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
